// File: rtl/piano_keyboard_display.sv
// Piano keyboard pixel generator: draws NUM_KEYS keys per line at a
// frame-latched offset, lighting each key for HOLD_FRAMES after a hit.
module piano_keyboard_display #(
    parameter int         NUM_KEYS    = 8,
    parameter int         KEY_W       = 38,
    parameter int         GAP         = 2,
    parameter int         KEY_H       = 136,
    parameter int         HOLD_FRAMES = 15,
    parameter logic [2:0] KEY_COLOR   = 3'b111,
    parameter logic [2:0] LIT_COLOR   = 3'b100
) (
    input  logic                clk_lcd,
    input  logic                rst_n,
    input  logic                flagh,
    input  logic                flagv,
    input  logic                rgb_en,
    input  logic [9:0]          hcount_reg,
    input  logic [8:0]          Vcount_reg,
    input  logic [9:0]          offset,
    input  logic [NUM_KEYS-1:0] key_hit,
    output logic                data_RED,
    output logic                data_GREEN,
    output logic                data_BLUE
);

    localparam int TW   = $clog2(HOLD_FRAMES + 1);
    localparam int IW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CMAX = (KEY_W > GAP) ? ((KEY_W > 2) ? KEY_W : 2)
                                        : ((GAP > 2) ? GAP : 2);
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_W - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_KEYS - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state, state_n, st_e;
    logic [IW-1:0] idx, idx_n, idx_e;
    logic [CW-1:0] col, col_n, col_e;

    logic                flagv_q;
    logic                tick;
    logic [9:0]          offset_q;
    logic [TW-1:0]       timer [NUM_KEYS];
    logic [NUM_KEYS-1:0] lit;
    logic                match;
    logic                in_rows;
    logic [2:0]          rgb_d;
    logic [2:0]          rgb_q;

    assign tick    = flagv_q & ~flagv;
    assign match   = flagh & flagv & (hcount_reg == offset_q);
    assign in_rows = 32'(Vcount_reg) < KEY_H;

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            flagv_q  <= 1'b0;
            offset_q <= '0;
        end else begin
            flagv_q <= flagv;
            if (tick)
                offset_q <= offset;
        end
    end

    // A hit in the same cycle as the frame tick reloads rather than decrements.
    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++)
                timer[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_hit[i])
                    timer[i] <= HOLD_LD;
                else if (tick && timer[i] != '0)
                    timer[i] <= timer[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++)
            lit[i] = (timer[i] != '0);
    end

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            col   <= col_n;
        end
    end

    // The offset match cycle is itself pixel 0 of key 0, so it is
    // folded in as an effective KEY state before advancing the counters.
    always_comb begin
        st_e  = state;
        idx_e = idx;
        col_e = col;
        if (state == S_IDLE && match) begin
            st_e  = S_KEY;
            idx_e = '0;
            col_e = '0;
        end
        state_n = st_e;
        idx_n   = idx_e;
        col_n   = col_e;
        unique case (st_e)
            S_IDLE: begin
            end
            S_KEY: begin
                if (col_e == KEY_LAST) begin
                    col_n = '0;
                    if (idx_e == IDX_LAST)
                        state_n = S_DONE;
                    else if (GAP > 0)
                        state_n = S_GAP;
                    else
                        idx_n = idx_e + 1'b1;
                end else begin
                    col_n = col_e + 1'b1;
                end
            end
            S_GAP: begin
                if (col_e == GAP_LAST) begin
                    state_n = S_KEY;
                    idx_n   = idx_e + 1'b1;
                    col_n   = '0;
                end else begin
                    col_n = col_e + 1'b1;
                end
            end
            S_DONE: begin
            end
            default: state_n = S_IDLE;
        endcase
        if (!flagh) begin
            state_n = S_IDLE;
            idx_n   = '0;
            col_n   = '0;
        end
    end

    always_comb begin
        rgb_d = 3'b000;
        if (flagh && flagv && in_rows && st_e == S_KEY)
            rgb_d = lit[idx_e] ? LIT_COLOR : KEY_COLOR;
    end

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q      <= 3'b000;
            data_RED   <= 1'b0;
            data_GREEN <= 1'b0;
            data_BLUE  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            if (rgb_en)
                {data_RED, data_GREEN, data_BLUE} <= rgb_q;
        end
    end

endmodule

// File: tb/tb_piano_keyboard_display.sv
// Directed bench for piano_keyboard_display: 4 keys, 3-frame hold,
// expected pixels from key geometry and hand-set lit masks per frame.
module tb_piano_keyboard_display;

    logic       clk_lcd = 1'b0;
    logic       rst_n;
    logic       flagh;
    logic       flagv;
    logic       rgb_en;
    logic [9:0] hcount_reg;
    logic [8:0] Vcount_reg;
    logic [9:0] offset;
    logic [3:0] key_hit;
    logic       data_RED;
    logic       data_GREEN;
    logic       data_BLUE;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] q1 = 3'b000;
    logic [2:0] q2 = 3'b000;
    int         exp_off = 0;
    logic [3:0] exp_lit = 4'b0000;

    piano_keyboard_display #(
        .NUM_KEYS   (4),
        .KEY_W      (38),
        .GAP        (2),
        .KEY_H      (136),
        .HOLD_FRAMES(3),
        .KEY_COLOR  (3'b111),
        .LIT_COLOR  (3'b100)
    ) dut (
        .clk_lcd   (clk_lcd),
        .rst_n     (rst_n),
        .flagh     (flagh),
        .flagv     (flagv),
        .rgb_en    (rgb_en),
        .hcount_reg(hcount_reg),
        .Vcount_reg(Vcount_reg),
        .offset    (offset),
        .key_hit   (key_hit),
        .data_RED  (data_RED),
        .data_GREEN(data_GREEN),
        .data_BLUE (data_BLUE)
    );

    always #5 clk_lcd = ~clk_lcd;

    // Keys occupy [off+40k, off+40k+37] for k=0..3 on rows 0..135.
    function automatic logic [2:0] model(logic fh, logic fv, int h, int v);
        int rel;
        if (!(fh && fv) || v >= 136 || h < exp_off)
            return 3'b000;
        rel = h - exp_off;
        if (rel / 40 >= 4 || rel % 40 >= 38)
            return 3'b000;
        return exp_lit[rel / 40] ? 3'b100 : 3'b111;
    endfunction

    task automatic check(string tag, logic [2:0] exp);
        logic [2:0] obs;
        obs = {data_RED, data_GREEN, data_BLUE};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, logic fh, logic fv, int h, int v,
                        logic [3:0] hit, logic en);
        logic [2:0] e;
        flagh      = fh;
        flagv      = fv;
        hcount_reg = h[9:0];
        Vcount_reg = v[8:0];
        key_hit    = hit;
        rgb_en     = en;
        check(tag, q2);
        e = model(fh, fv, h, v);
        @(posedge clk_lcd);
        if (en)
            q2 = q1;
        q1 = e;
        exp_lit = exp_lit | hit;
        @(negedge clk_lcd);
    endtask

    task automatic line(string tag, int v, int hs, int he);
        for (int h = hs; h <= he; h++)
            step(tag, 1'b1, 1'b1, h, v, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++)
            step(tag, 1'b0, 1'b1, 0, v, 4'b0000, 1'b1);
    endtask

    task automatic frame_end(logic [3:0] hit, logic [3:0] lit_after);
        step("tick", 1'b0, 1'b0, 0, 0, hit, 1'b1);
        exp_off = int'(offset);
        exp_lit = lit_after;
        step("vblank", 1'b0, 1'b0, 0, 0, 4'b0000, 1'b1);
        step("vblank", 1'b0, 1'b0, 0, 0, 4'b0000, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        flagh      = 1'b0;
        flagv      = 1'b0;
        rgb_en     = 1'b1;
        hcount_reg = '0;
        Vcount_reg = '0;
        offset     = 10'd10;
        key_hit    = '0;
        repeat (3) @(posedge clk_lcd);
        @(negedge clk_lcd);
        check("reset", 3'b000);
        rst_n = 1'b1;

        // First frame after reset draws at offset 0.
        line("rst_frame", 0, 0, 179);
        frame_end(4'b0000, 4'b0000);

        line("geom_v0", 0, 0, 179);
        line("geom_v135", 135, 0, 179);
        line("geom_v136", 136, 0, 179);

        step("hit2", 1'b0, 1'b1, 0, 136, 4'b0100, 1'b1);
        line("hit_f0", 0, 0, 179);
        frame_end(4'b0000, 4'b0100);
        line("hit_f1", 0, 0, 179);
        frame_end(4'b0000, 4'b0100);
        line("hit_f2", 0, 0, 179);
        frame_end(4'b0000, 4'b0000);
        line("hit_f3", 0, 0, 179);

        step("hit1", 1'b0, 1'b1, 0, 0, 4'b0010, 1'b1);
        line("sim_pre0", 0, 0, 179);
        frame_end(4'b0000, 4'b0010);
        line("sim_pre1", 0, 0, 179);
        frame_end(4'b0000, 4'b0010);
        line("sim_pre2", 0, 0, 179);
        frame_end(4'b0010, 4'b0010);
        line("sim_f1", 0, 0, 179);
        frame_end(4'b0000, 4'b0010);
        line("sim_f2", 0, 0, 179);
        frame_end(4'b0000, 4'b0010);
        line("sim_f3", 0, 0, 179);
        frame_end(4'b0000, 4'b0000);
        line("sim_off", 0, 0, 179);

        line("off_v59", 59, 0, 219);
        offset = 10'd50;
        line("off_v60", 60, 0, 219);
        line("off_v135", 135, 0, 219);
        frame_end(4'b0000, 4'b0000);
        line("off_next", 0, 0, 219);

        offset = 10'd1000;
        frame_end(4'b0000, 4'b0000);
        line("trunc_l0", 0, 990, 1023);
        line("trunc_l1", 1, 990, 1023);

        offset = 10'd10;
        frame_end(4'b0000, 4'b0000);
        for (int h = 0; h <= 44; h++)
            step("en_pre", 1'b1, 1'b1, h, 0, 4'b0000, 1'b1);
        for (int h = 45; h <= 49; h++)
            step("en_freeze", 1'b1, 1'b1, h, 0, 4'b0000, 1'b0);
        for (int h = 50; h <= 179; h++)
            step("en_post", 1'b1, 1'b1, h, 0, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++)
            step("en_blank", 1'b0, 1'b1, 0, 0, 4'b0000, 1'b1);

        for (int h = 0; h <= 20; h++)
            step("rst_pre", 1'b1, 1'b1, h, 1, 4'b0000, 1'b1);
        check("rst_midkey", 3'b111);
        rst_n = 1'b0;
        #1;
        check("rst_async", 3'b000);
        q1      = 3'b000;
        q2      = 3'b000;
        exp_off = 0;
        exp_lit = 4'b0000;
        step("rst_hold", 1'b0, 1'b1, 0, 1, 4'b0000, 1'b1);
        step("rst_hold", 1'b0, 1'b1, 0, 1, 4'b0000, 1'b1);
        rst_n = 1'b1;
        line("post_rst", 0, 0, 179);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piano_keyboard_display.md
# piano_keyboard_display

Parametrised LCD pixel generator that draws a row of NUM_KEYS piano keys starting at a programmable horizontal offset. Each key is KEY_W pixels wide, separated by GAP black pixels, and KEY_H lines tall from the top of the active area. A key is shown in LIT_COLOR for HOLD_FRAMES frames after a key_hit pulse, and in KEY_COLOR otherwise. The block sits between the LCD timing generator, which supplies hcount_reg, Vcount_reg, flagh, flagv and rgb_en, and the panel RGB pins.

## Interface
- NUM_KEYS, 8: number of keys drawn; 1..32.
- KEY_W, 38: key width in pixels; at least 1.
- GAP, 2: black pixels between adjacent keys; 0 is allowed.
- KEY_H, 136: key height in lines.
- HOLD_FRAMES, 15: frames a key stays lit after a hit; at least 1.
- KEY_COLOR, 3'b111: {R,G,B} colour of an idle key.
- LIT_COLOR, 3'b100: {R,G,B} colour of a lit key.

Ports:
- clk_lcd, in, 1: pixel clock. All logic is synchronous to its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flagh, in, 1: horizontal active-area flag.
- flagv, in, 1: vertical active-area flag.
- rgb_en, in, 1: enable for the output register.
- hcount_reg, in, 10: pixel column. It increments by exactly 1 per clk_lcd while flagh is high.
- Vcount_reg, in, 9: line number.
- offset, in, 10: x position of the left edge of key 0.
- key_hit, in, NUM_KEYS: one bit per key; a high level in any cycle retriggers that key.
- data_RED, out, 1: red pixel output.
- data_GREEN, out, 1: green pixel output.
- data_BLUE, out, 1: blue pixel output.

## Operation
- Frame tick: flagv is registered as flagv_q. tick = flagv_q & ~flagv, i.e. the falling edge of flagv, registered internally.
- Offset latch: offset_q loads offset on tick. Only offset_q is used for drawing, so a new offset takes effect on the next frame and never tears mid-frame.
- Hold timers: one down-counter per key, width clog2(HOLD_FRAMES+1).
  - key_hit[i] high: timer i loads HOLD_FRAMES.
  - Otherwise, on tick: timer i decrements if it is nonzero.
  - key_hit[i] and tick in the same cycle: the load wins.
  - lit[i] = (timer i != 0).
- Key tracker FSM. State registers: idx (key index), col (pixel counter within the current key or gap). States:
  - IDLE: entered on reset and whenever flagh=0. If flagh&flagv and hcount_reg==offset_q, go to KEY with idx=0, col=0.
  - KEY: if col==KEY_W-1, then go to DONE when idx==NUM_KEYS-1. Otherwise go to GAP with col=0 when GAP>0, or to KEY with idx+1 and col=0 when GAP=0. In all other cases col increments.
  - GAP: if col==GAP-1, go to KEY with idx+1 and col=0; otherwise col increments.
  - DONE: hold until flagh=0, then go to IDLE.
- The FSM re-arms every line, independently of Vcount_reg. A line that ends mid-key truncates the drawing, and the next line restarts from key 0.
- The match on hcount_reg==offset_q is evaluated in the same cycle as the comparison. The pixel at column offset_q is therefore the first pixel of key 0.
- Pixel stage 1 (combinational from the current state and inputs, registered into rgb_q):
  - If flagh&flagv&(Vcount_reg<KEY_H) and the pixel is a key pixel: rgb_q = lit[idx] ? LIT_COLOR : KEY_COLOR.
  - A key pixel is either the entry cycle (IDLE with a match) or the KEY state.
  - All other cases, including GAP, DONE and outside the active area: rgb_q = 3'b000.
- Stage 2: when rgb_en=1, {data_RED,data_GREEN,data_BLUE} <= rgb_q. When rgb_en=0, the outputs hold their value.

## Timing
- Reset values: all outputs 0, rgb_q=0, state IDLE, idx=0, col=0, all timers 0, offset_q=0, flagv_q=0.
- Latency: hcount_reg at cycle n appears on rgb_q at edge n+1 and on the outputs at edge n+2, given rgb_en=1.
- A key_hit registered at edge n affects rgb_q from edge n+1 onward.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). Drawing resumes at the first offset_q match after rst_n is released.
- Because offset_q resets to 0, the frame after reset draws at offset 0 until the first tick loads offset.
- offset_q+total width beyond the line: the FSM simply never reaches DONE on that line. No wrap-around to the left edge occurs.

## Test plan
- Geometry: NUM_KEYS=4, KEY_W=38, GAP=2, offset=10 applied before tick, no hits.
  - Outputs are 111 for columns 10–47, 50–87, 90–127 and 130–167, and 000 elsewhere, each appearing 2 cycles after its hcount_reg.
  - Lines with Vcount_reg ≥ 136 are all 000.
- Hit and hold: pulse key_hit[2] in frame 0 with HOLD_FRAMES=3.
  - Key 2 (columns 90–127) is 100 immediately after the pulse, and for the next 2 full frames.
  - It reverts to 111 after the 3rd tick.
- Simultaneous hit and tick: key_hit[1]=1 on the tick cycle while timer 1=1.
  - Timer 1 becomes 3, not 0, and key 1 stays lit.
- Offset change mid-frame: offset changes from 10 to 50 at line 60.
  - Lines 60–135 of the current frame still draw at 10.
  - The next frame draws key 0 at columns 50–87.
- Truncation and re-arm: offset=1000.
  - Key 0 is drawn at columns 1000–1023, and flagh then drops.
  - The next line again starts key 0 at 1000.
  - The FSM is back in IDLE during blanking.
- Reset and rgb_en:
  - Assert rst_n=0 mid-key: outputs are 0 within the same cycle.
  - With rgb_en=0 for 5 cycles while drawing, the outputs freeze at their last value.
